vector_register_file_stream: RTL and testbench

- Next-generation vector register file: NUM_VECTORES registers, each VECTOR_SIZE lanes of WIDTH bits, with two asynchronous read ports.
- Full-vector write port gains a per-lane write mask.
- Adds an element-streaming write port that fills one register lane-by-lane over multiple cycles, with valid/ready handshake, busy scoreboard and conflict flag.
- Sits between the vector decode stage and the vector ALU / memory load path.

---
 rtl/vrf_pkg.sv | 12 +
 rtl/vrf_stream_ctrl.sv | 76 +++++++
 rtl/vector_register_file_stream.sv | 75 +++++++
 tb/tb_vector_register_file_stream.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vrf_pkg.sv
// Shared types for the vector register file: streaming FSM states and
// index typedefs sized for the default configuration.
package vrf_pkg;
  localparam int VRF_WIDTH        = 16;
  localparam int VRF_VECTOR_SIZE  = 16;
  localparam int VRF_NUM_VECTORES = 8;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} vrf_state_t;

  typedef logic [$clog2(VRF_VECTOR_SIZE)-1:0]  lane_idx_t;
  typedef logic [$clog2(VRF_NUM_VECTORES)-1:0] reg_idx_t;
endpackage

// File: rtl/vrf_stream_ctrl.sv
// Element-streaming fill controller: FSM, lane counter, target latch,
// busy scoreboard and full-write conflict detection.
module vrf_stream_ctrl
  import vrf_pkg::*;
#(
  parameter int VECTOR_SIZE  = VRF_VECTOR_SIZE,
  parameter int NUM_VECTORES = VRF_NUM_VECTORES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            stream_start,
  input  logic [$clog2(NUM_VECTORES)-1:0] stream_vreg,
  input  logic                            stream_valid,
  input  logic                            we3,
  input  logic [$clog2(NUM_VECTORES)-1:0] v3,
  output logic                            stream_ready,
  output logic                            stream_done,
  output logic [NUM_VECTORES-1:0]         busy,
  output logic                            wr_conflict,
  output logic                            full_we,
  output logic                            s_we,
  output logic [$clog2(VECTOR_SIZE)-1:0]  s_lane,
  output logic [$clog2(NUM_VECTORES)-1:0] s_idx
);
  localparam int LW = $clog2(VECTOR_SIZE);
  localparam int RW = $clog2(NUM_VECTORES);

  vrf_state_t    state, state_nxt;
  logic [LW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] target, target_nxt;
  logic          conflict;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      target      <= '0;
      wr_conflict <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      target      <= target_nxt;
      wr_conflict <= conflict;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    target_nxt = target;
    s_we       = 1'b0;
    case (state)
      IDLE: if (stream_start) begin
        state_nxt  = STREAM;
        cnt_nxt    = '0;
        target_nxt = stream_vreg;
      end
      STREAM: if (stream_valid) begin
        s_we = 1'b1;
        if (cnt == LW'(VECTOR_SIZE - 1)) state_nxt = DONE;
        else                             cnt_nxt   = cnt + 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Target stays locked through DONE, so a write landing there is still dropped.
  assign conflict     = we3 && (state != IDLE) && (v3 == target);
  assign full_we      = we3 && !conflict;
  assign stream_ready = (state == STREAM);
  assign stream_done  = (state == DONE);
  assign busy         = (state != IDLE) ? (NUM_VECTORES'(1) << target) : '0;
  assign s_lane       = cnt;
  assign s_idx        = target;
endmodule

// File: rtl/vector_register_file_stream.sv
// Vector register file with two async read ports, a masked full-vector
// write port and a lane-by-lane streaming write port.
module vector_register_file_stream
  import vrf_pkg::*;
#(
  parameter int WIDTH        = VRF_WIDTH,
  parameter int VECTOR_SIZE  = VRF_VECTOR_SIZE,
  parameter int NUM_VECTORES = VRF_NUM_VECTORES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [$clog2(NUM_VECTORES)-1:0] v1,
  input  logic [$clog2(NUM_VECTORES)-1:0] v2,
  output logic [WIDTH-1:0]                vd1 [VECTOR_SIZE],
  output logic [WIDTH-1:0]                vd2 [VECTOR_SIZE],
  input  logic                            we3,
  input  logic [$clog2(NUM_VECTORES)-1:0] v3,
  input  logic [WIDTH-1:0]                wd3 [VECTOR_SIZE],
  input  logic [VECTOR_SIZE-1:0]          wmask3,
  input  logic                            stream_start,
  input  logic [$clog2(NUM_VECTORES)-1:0] stream_vreg,
  input  logic                            stream_valid,
  input  logic [WIDTH-1:0]                stream_data,
  output logic                            stream_ready,
  output logic                            stream_done,
  output logic [NUM_VECTORES-1:0]         busy,
  output logic                            wr_conflict
);
  localparam int LW = $clog2(VECTOR_SIZE);
  localparam int RW = $clog2(NUM_VECTORES);

  logic [WIDTH-1:0] regs [NUM_VECTORES][VECTOR_SIZE];
  logic             full_we, s_we;
  logic [LW-1:0]    s_lane;
  logic [RW-1:0]    s_idx;

  vrf_stream_ctrl #(.VECTOR_SIZE(VECTOR_SIZE), .NUM_VECTORES(NUM_VECTORES)) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .stream_start (stream_start),
    .stream_vreg  (stream_vreg),
    .stream_valid (stream_valid),
    .we3          (we3),
    .v3           (v3),
    .stream_ready (stream_ready),
    .stream_done  (stream_done),
    .busy         (busy),
    .wr_conflict  (wr_conflict),
    .full_we      (full_we),
    .s_we         (s_we),
    .s_lane       (s_lane),
    .s_idx        (s_idx)
  );

  // A stream beat and an accepted full write never target the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_VECTORES; i++)
        for (int k = 0; k < VECTOR_SIZE; k++)
          regs[i][k] <= '0;
    end else begin
      if (full_we)
        for (int k = 0; k < VECTOR_SIZE; k++)
          if (wmask3[k]) regs[v3][k] <= wd3[k];
      if (s_we) regs[s_idx][s_lane] <= stream_data;
    end
  end

  always_comb begin
    for (int k = 0; k < VECTOR_SIZE; k++) begin
      vd1[k] = regs[v1][k];
      vd2[k] = regs[v2][k];
    end
  end
endmodule

// File: tb/tb_vector_register_file_stream.sv
// Directed and randomized bench for vector_register_file_stream against an
// array-based reference model.
module tb_vector_register_file_stream;
  localparam int W  = 16;
  localparam int VS = 16;
  localparam int NV = 8;

  logic          clk, rst;
  logic [2:0]    v1, v2, v3, stream_vreg;
  logic [W-1:0]  vd1 [VS];
  logic [W-1:0]  vd2 [VS];
  logic [W-1:0]  wd3 [VS];
  logic          we3, stream_start, stream_valid;
  logic [VS-1:0] wmask3;
  logic [W-1:0]  stream_data;
  logic          stream_ready, stream_done, wr_conflict;
  logic [NV-1:0] busy;

  vector_register_file_stream #(.WIDTH(W), .VECTOR_SIZE(VS), .NUM_VECTORES(NV)) dut (
    .clk(clk), .rst(rst), .v1(v1), .v2(v2), .vd1(vd1), .vd2(vd2),
    .we3(we3), .v3(v3), .wd3(wd3), .wmask3(wmask3),
    .stream_start(stream_start), .stream_vreg(stream_vreg),
    .stream_valid(stream_valid), .stream_data(stream_data),
    .stream_ready(stream_ready), .stream_done(stream_done),
    .busy(busy), .wr_conflict(wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register contents plus the streaming job in flight.
  logic [W-1:0] m [NV][VS];
  bit           m_stream, m_done, m_conf;
  logic [2:0]   m_tgt;
  int           m_cnt;
  int           checks = 0, errors = 0;
  int           dones = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("stream_ready", 32'(stream_ready), 32'(m_stream));
    chk("stream_done",  32'(stream_done),  32'(m_done));
    chk("busy",         32'(busy), (m_stream || m_done) ? (32'd1 << m_tgt) : 32'd0);
    chk("wr_conflict",  32'(wr_conflict),  32'(m_conf));
    for (int k = 0; k < VS; k++) begin
      chk($sformatf("vd1[r%0d][%0d]", v1, k), 32'(vd1[k]), 32'(m[v1][k]));
      chk($sformatf("vd2[r%0d][%0d]", v2, k), 32'(vd2[k]), 32'(m[v2][k]));
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NV; i++)
      for (int k = 0; k < VS; k++) m[i][k] = '0;
    m_stream = 0; m_done = 0; m_conf = 0; m_tgt = '0; m_cnt = 0;
  endtask

  // One clock: advance the model from the inputs seen at the edge, then check.
  task automatic step();
    bit conf;
    @(posedge clk);
    conf = we3 && (m_stream || m_done) && (v3 == m_tgt);
    if (we3 && !conf)
      for (int k = 0; k < VS; k++) if (wmask3[k]) m[v3][k] = wd3[k];
    if (m_done) m_done = 0;
    else if (m_stream) begin
      if (stream_valid) begin
        m[m_tgt][m_cnt] = stream_data;
        m_cnt++;
        if (m_cnt == VS) begin m_stream = 0; m_done = 1; end
      end
    end else if (stream_start) begin
      m_stream = 1; m_tgt = stream_vreg; m_cnt = 0;
    end
    m_conf = conf;
    #1;
    if (stream_done) dones++;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    model_clear();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_wd(logic [W-1:0] val);
    for (int k = 0; k < VS; k++) wd3[k] = val;
  endtask

  task automatic idle_inputs();
    we3 = 0; v3 = '0; wmask3 = '0; set_wd('0);
    stream_start = 0; stream_vreg = '0; stream_valid = 0; stream_data = '0;
  endtask

  // Fill register r with base+lane; toggle inserts an idle cycle between beats.
  task automatic stream_fill(logic [2:0] r, logic [W-1:0] base, bit toggle);
    int guard = 0;
    stream_start = 1; stream_vreg = r;
    step();
    stream_start = 0;
    while (m_stream && guard < 100) begin
      stream_valid = toggle ? ~stream_valid : 1'b1;
      stream_data  = base + W'(m_cnt);
      step();
      guard++;
    end
    chk("stream_finished", 32'(m_stream), 32'd0);
    stream_valid = 0;
    step();
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    v1 = 3'd0; v2 = 3'd7;
    idle_inputs();
    #3;
    model_clear();
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Masked full write.
    we3 = 1; v3 = 3'd2; set_wd(16'hABCD); wmask3 = 16'h00FF;
    step();
    idle_inputs(); v1 = 3'd2;
    step();
    chk("masked_lane7", 32'(vd1[7]), 32'hABCD);
    chk("masked_lane8", 32'(vd1[8]), 32'h0000);

    // Continuous stream to reg 4, then a stalling stream to reg 5.
    d0 = dones;
    v2 = 3'd4;
    stream_fill(3'd4, 16'h1000, 1'b0);
    chk("done_once_r4", 32'(dones - d0), 32'd1);
    chk("r4_lane15", 32'(vd2[15]), 32'h100F);
    d0 = dones;
    v1 = 3'd5;
    stream_fill(3'd5, 16'h5000, 1'b1);
    chk("done_once_r5", 32'(dones - d0), 32'd1);

    // Conflicting and non-conflicting full writes during a stream to reg 3.
    v1 = 3'd3; v2 = 3'd1;
    stream_start = 1; stream_vreg = 3'd3;
    step();
    stream_start = 0; stream_valid = 1; stream_data = 16'h3333;
    step();
    we3 = 1; v3 = 3'd3; set_wd(16'h2222); wmask3 = '1;
    step();
    chk("conflict_pulse", 32'(wr_conflict), 32'd1);
    v3 = 3'd1;
    step();
    chk("r1_written", 32'(vd2[0]), 32'h2222);
    we3 = 0;
    while (m_stream) step();
    step();

    // Full write to the register being claimed in the same edge.
    we3 = 1; v3 = 3'd7; set_wd(16'h5555); wmask3 = '1;
    stream_start = 1; stream_vreg = 3'd7; v1 = 3'd7;
    step();
    idle_inputs();
    chk("same_edge_write", 32'(vd1[3]), 32'h5555);
    stream_valid = 1;
    while (m_stream) step();
    step();

    // Reset after 5 beats into reg 6, then a fresh stream.
    idle_inputs(); v1 = 3'd6;
    stream_start = 1; stream_vreg = 3'd6;
    step();
    stream_start = 0; stream_valid = 1; stream_data = 16'h6666;
    repeat (5) step();
    d0 = dones;
    do_reset();
    chk("abort_lane0", 32'(vd1[0]), 32'h0);
    idle_inputs();
    step();
    chk("no_done_after_abort", 32'(dones - d0), 32'd0);
    stream_fill(3'd6, 16'h6000, 1'b0);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      v1 = 3'($urandom_range(0, NV - 1));
      v2 = 3'($urandom_range(0, NV - 1));
      we3 = ($urandom_range(0, 2) == 0);
      v3 = ($urandom_range(0, 2) == 0) ? m_tgt : 3'($urandom_range(0, NV - 1));
      wmask3 = VS'($urandom);
      for (int k = 0; k < VS; k++) wd3[k] = W'($urandom);
      stream_start = ($urandom_range(0, 5) == 0);
      stream_vreg  = 3'($urandom_range(0, NV - 1));
      stream_valid = ($urandom_range(0, 3) != 0);
      stream_data  = W'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
